// File: rtl/countdown_timer_bcd_pkg.sv
// Shared constants for the microwave cook-time countdown: state codes and BCD limits.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package countdown_timer_bcd_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    // Saturate an operator-supplied digit to the largest legal value for its position.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit, input logic [3:0] limit);
        return (digit > limit) ? limit : digit;
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_digit_dec.sv
// One BCD digit of the down-counter; wraps 0 -> max_val and raises borrow_out.
// Latency: combinational.
// Backpressure: none; dec_en is the borrow from the next less significant digit.
module bcd_digit_dec (
    input  logic [3:0] digit,
    input  logic       dec_en,
    input  logic [3:0] max_val,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    // Decrement with wrap; borrow only when an enabled decrement crosses zero.
    always_comb begin
        next_digit = digit;
        borrow_out = 1'b0;
        if (dec_en) begin
            if (digit == 4'd0) begin
                next_digit = max_val;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer_bcd.sv
// MM:SS BCD cook-time countdown, one decrement per TICKS_PER_SEC rising edges of tick_in.
// Latency: new time visible one clk after the edge that samples tick_rise.
// Backpressure: none; commands are single-cycle levels (clear > load > pause > start). Optional DOOR_INTERLOCK_EN adds door_open.
module countdown_timer_bcd
    import countdown_timer_bcd_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
`ifdef DOOR_INTERLOCK_EN
    input  logic       door_open,
`endif
    input  logic [3:0] min_tens_in,
    input  logic [3:0] min_units_in,
    input  logic [3:0] sec_tens_in,
    input  logic [3:0] sec_units_in,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       running,
    output logic       done
);

    localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_SEC - 1);

    logic [1:0] state, state_nxt;
    logic [7:0] presc, presc_nxt;
    logic       tick_q;
    logic       tick_rise;
    logic       sec_step;
    logic       door;
    logic       time_zero;
    logic       dec_zero;
    logic [3:0] mt_nxt, mu_nxt, st_nxt, su_nxt;
    logic [3:0] mt_dec, mu_dec, st_dec, su_dec;
    logic       su_borrow, st_borrow, mu_borrow, mt_borrow;

`ifdef DOOR_INTERLOCK_EN
    assign door = door_open;
`else
    assign door = 1'b0;
`endif

    assign tick_rise = tick_in & ~tick_q;
    assign sec_step  = tick_rise && (presc == PRESC_LAST);
    assign time_zero = ({min_tens, min_units, sec_tens, sec_units} == 16'h0000);
    // An underflow out of min_tens would be a wrap, never a real terminal count.
    assign dec_zero  = ({mt_dec, mu_dec, st_dec, su_dec} == 16'h0000) && !mt_borrow;

    assign running = (state == ST_RUN);
    assign done    = (state == ST_DONE);

    bcd_digit_dec u_sec_units (.digit(sec_units), .dec_en(sec_step),  .max_val(DIGIT_MAX),
                               .next_digit(su_dec), .borrow_out(su_borrow));
    bcd_digit_dec u_sec_tens  (.digit(sec_tens),  .dec_en(su_borrow), .max_val(SEC_TENS_MAX),
                               .next_digit(st_dec), .borrow_out(st_borrow));
    bcd_digit_dec u_min_units (.digit(min_units), .dec_en(st_borrow), .max_val(DIGIT_MAX),
                               .next_digit(mu_dec), .borrow_out(mu_borrow));
    bcd_digit_dec u_min_tens  (.digit(min_tens),  .dec_en(mu_borrow), .max_val(DIGIT_MAX),
                               .next_digit(mt_dec), .borrow_out(mt_borrow));

    // Command arbitration, prescaling and decrement selection for the next cycle.
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        mt_nxt    = min_tens;
        mu_nxt    = min_units;
        st_nxt    = sec_tens;
        su_nxt    = sec_units;
        if (clear) begin
            state_nxt = ST_IDLE;
            presc_nxt = 8'd0;
            mt_nxt    = 4'd0;
            mu_nxt    = 4'd0;
            st_nxt    = 4'd0;
            su_nxt    = 4'd0;
        end else if (state == ST_RUN && door) begin
            // Door opened mid-cook: freeze time and prescale, no decrement this cycle.
            state_nxt = ST_PAUSED;
        end else if (load && state != ST_RUN) begin
            state_nxt = ST_IDLE;
            presc_nxt = 8'd0;
            mt_nxt    = bcd_clamp(min_tens_in,  DIGIT_MAX);
            mu_nxt    = bcd_clamp(min_units_in, DIGIT_MAX);
            st_nxt    = bcd_clamp(sec_tens_in,  SEC_TENS_MAX);
            su_nxt    = bcd_clamp(sec_units_in, DIGIT_MAX);
        end else if (state == ST_RUN) begin
            if (pause) begin
                // Prescale is held so a partial second survives the pause.
                state_nxt = ST_PAUSED;
            end else begin
                if (tick_rise) begin
                    presc_nxt = sec_step ? 8'd0 : presc + 8'd1;
                end
                if (sec_step) begin
                    mt_nxt = mt_dec;
                    mu_nxt = mu_dec;
                    st_nxt = st_dec;
                    su_nxt = su_dec;
                    if (dec_zero) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
        end else if (!pause && start && !door && !time_zero &&
                     (state == ST_IDLE || state == ST_PAUSED)) begin
            state_nxt = ST_RUN;
        end
    end

    // State, time digits, prescale and tick edge history with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            presc     <= 8'd0;
            tick_q    <= 1'b1;
            min_tens  <= 4'd0;
            min_units <= 4'd0;
            sec_tens  <= 4'd0;
            sec_units <= 4'd0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            tick_q    <= tick_in;
            min_tens  <= mt_nxt;
            min_units <= mu_nxt;
            sec_tens  <= st_nxt;
            sec_units <= su_nxt;
        end
    end

endmodule
